// File: rtl/bhargava_core.sv
// rtl/bhargava_core.sv - Bhargava MPEG scrambler byte-stream front end (pass-through mode)
//
// Purpose:
//    Buffers MPEG program-stream bytes in an internal FIFO and returns them
//    unchanged, in order, through a FIFO-style read port with 1-cycle read
//    latency. Provides programmable-full back-pressure, a sticky overflow
//    flag, an end-of-stream indication and debug counters (video PES start
//    codes, bytes in, bytes out).
//
// Ports:
//    clk            in   system clock, rising edge
//    rst_n          in   asynchronous active-low reset
//    clk_en         in   global clock enable; 0 freezes all state
//    mpeg_in        in   [7:0] input stream byte
//    mpeg_in_en     in   mpeg_in valid this cycle
//    stream_end     in   level: source has delivered its last byte
//    mpeg_out       out  [7:0] registered output byte
//    mpeg_rd        in   read request
//    mpeg_empty     out  FIFO holds no bytes
//    mpeg_prog_full out  occupancy >= PROG_FULL
//    stream_done    out  stream_end seen and FIFO drained
//    vid_cnt        out  [31:0] video PES start codes (00 00 01 Ex)
//    misc_in_cnt    out  [31:0] bytes accepted into the FIFO
//    vbuf_out_cnt   out  [31:0] bytes read from the FIFO
//    overflow       out  sticky: a write was dropped because the FIFO was full

module bhargava_core #(
   parameter int DEPTH     = 256,
   parameter int PROG_FULL = 240
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clk_en,
   input  logic [7:0]  mpeg_in,
   input  logic        mpeg_in_en,
   input  logic        stream_end,
   output logic [7:0]  mpeg_out,
   input  logic        mpeg_rd,
   output logic        mpeg_empty,
   output logic        mpeg_prog_full,
   output logic        stream_done,
   output logic [31:0] vid_cnt,
   output logic [31:0] misc_in_cnt,
   output logic [31:0] vbuf_out_cnt,
   output logic        overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
   localparam logic [PW-1:0] PFULL_P = PW'(PROG_FULL);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);

   // Storage. No reset: contents are meaningless once the pointers reset.
   logic [7:0]    mem_q [DEPTH];

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] occ;
   logic [PW-1:0] occ_d;

   logic [7:0]    out_q, out_d;
   logic          empty_q, empty_d;
   logic          pfull_q, pfull_d;
   logic          done_q, done_d;
   logic          ovf_q, ovf_d;

   // Last three accepted bytes, oldest in hist2.
   logic [7:0]    hist2_q, hist2_d;
   logic [7:0]    hist1_q, hist1_d;
   logic [7:0]    hist0_q, hist0_d;

   logic [31:0]   vid_q, vid_d;
   logic [31:0]   in_cnt_q, in_cnt_d;
   logic [31:0]   out_cnt_q, out_cnt_d;

   logic          rd_acc;
   logic          wr_acc;
   logic          start_hit;

   // ------------------------------------------------------------------
   // Handshake decisions
   // ------------------------------------------------------------------
   always_comb begin
      occ    = wr_ptr_q - rd_ptr_q;
      rd_acc = clk_en & mpeg_rd & ~empty_q;
      // A read in the same cycle frees a slot, so a full FIFO can still
      // take a byte; the slot being written is the one being read out.
      wr_acc = clk_en & mpeg_in_en & ((occ != DEPTH_P) | rd_acc);
   end

   // Video PES start code: 00 00 01 followed by a stream id of 0xE0..0xEF.
   assign start_hit = (hist2_q == 8'h00) && (hist1_q == 8'h00) &&
                      (hist0_q == 8'h01) && (mpeg_in[7:4] == 4'hE);

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      out_d     = out_q;
      ovf_d     = ovf_q;
      hist2_d   = hist2_q;
      hist1_d   = hist1_q;
      hist0_d   = hist0_q;
      vid_d     = vid_q;
      in_cnt_d  = in_cnt_q;
      out_cnt_d = out_cnt_q;

      if (rd_acc) begin
         rd_ptr_d  = rd_ptr_q + PTR_ONE;
         out_d     = mem_q[rd_ptr_q[AW-1:0]];
         out_cnt_d = out_cnt_q + 32'd1;
      end

      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
         in_cnt_d = in_cnt_q + 32'd1;
         hist2_d  = hist1_q;
         hist1_d  = hist0_q;
         hist0_d  = mpeg_in;
         if (start_hit) begin
            vid_d = vid_q + 32'd1;
         end
      end else if (clk_en && mpeg_in_en) begin
         ovf_d = 1'b1;
      end

      // Flags are registered from the post-edge occupancy so they are
      // exact in the cycle following the transfer.
      occ_d   = wr_ptr_d - rd_ptr_d;
      empty_d = (occ_d == '0);
      pfull_d = (occ_d >= PFULL_P);

      // Uses the visible empty flag, so done rises the cycle after empty
      // does; an arriving byte kills it immediately.
      done_d  = stream_end & empty_q & ~wr_acc;
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         out_q     <= 8'h00;
         empty_q   <= 1'b1;
         pfull_q   <= 1'b0;
         done_q    <= 1'b0;
         ovf_q     <= 1'b0;
         hist2_q   <= 8'hFF;
         hist1_q   <= 8'hFF;
         hist0_q   <= 8'hFF;
         vid_q     <= 32'd0;
         in_cnt_q  <= 32'd0;
         out_cnt_q <= 32'd0;
      end else if (clk_en) begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         out_q     <= out_d;
         empty_q   <= empty_d;
         pfull_q   <= pfull_d;
         done_q    <= done_d;
         ovf_q     <= ovf_d;
         hist2_q   <= hist2_d;
         hist1_q   <= hist1_d;
         hist0_q   <= hist0_d;
         vid_q     <= vid_d;
         in_cnt_q  <= in_cnt_d;
         out_cnt_q <= out_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem_q[wr_ptr_q[AW-1:0]] <= mpeg_in;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign mpeg_out       = out_q;
   assign mpeg_empty     = empty_q;
   assign mpeg_prog_full = pfull_q;
   assign stream_done    = done_q;
   assign overflow       = ovf_q;
   assign vid_cnt        = vid_q;
   assign misc_in_cnt    = in_cnt_q;
   assign vbuf_out_cnt   = out_cnt_q;

endmodule

// File: tb/tb_bhargava_core.sv
// tb/tb_bhargava_core.sv - randomized self-checking bench for bhargava_core

module tb_bhargava_core;

   localparam int DEPTH     = 256;
   localparam int PROG_FULL = 240;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clk_en;
   logic [7:0]  mpeg_in;
   logic        mpeg_in_en;
   logic        stream_end;
   logic [7:0]  mpeg_out;
   logic        mpeg_rd;
   logic        mpeg_empty;
   logic        mpeg_prog_full;
   logic        stream_done;
   logic [31:0] vid_cnt;
   logic [31:0] misc_in_cnt;
   logic [31:0] vbuf_out_cnt;
   logic        overflow;

   bhargava_core #(.DEPTH(DEPTH), .PROG_FULL(PROG_FULL)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .clk_en         (clk_en),
      .mpeg_in        (mpeg_in),
      .mpeg_in_en     (mpeg_in_en),
      .stream_end     (stream_end),
      .mpeg_out       (mpeg_out),
      .mpeg_rd        (mpeg_rd),
      .mpeg_empty     (mpeg_empty),
      .mpeg_prog_full (mpeg_prog_full),
      .stream_done    (stream_done),
      .vid_cnt        (vid_cnt),
      .misc_in_cnt    (misc_in_cnt),
      .vbuf_out_cnt   (vbuf_out_cnt),
      .overflow       (overflow)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: a byte queue plus plain counters.
   logic [7:0]  m_q[$];
   logic [7:0]  m_win[$];
   int unsigned m_vid, m_in, m_out;
   bit          m_ovf, m_done;
   logic [7:0]  m_dout;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] w1(input logic b);
      return {31'd0, b};
   endfunction

   function automatic logic [31:0] w8(input logic [7:0] b);
      return {24'd0, b};
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_win.delete();
      m_vid  = 0;
      m_in   = 0;
      m_out  = 0;
      m_ovf  = 1'b0;
      m_done = 1'b0;
      m_dout = 8'h00;
   endtask

   task automatic model_edge(input bit en, input bit we, input logic [7:0] d,
                             input bit rd, input bit se);
      bit was_empty, racc, wacc;
      if (!en) return;
      was_empty = (m_q.size() == 0);
      racc = rd && !was_empty;
      wacc = we && ((m_q.size() < DEPTH) || racc);
      if (racc) begin
         m_dout = m_q.pop_front();
         m_out++;
      end
      if (wacc) begin
         if (m_win.size() == 3 && m_win[0] == 8'h00 && m_win[1] == 8'h00 &&
             m_win[2] == 8'h01 && d >= 8'hE0 && d <= 8'hEF)
            m_vid++;
         m_win.push_back(d);
         if (m_win.size() > 3) void'(m_win.pop_front());
         m_q.push_back(d);
         m_in++;
      end else if (we) begin
         m_ovf = 1'b1;
      end
      m_done = se && was_empty && !wacc;
   endtask

   task automatic check_all(input string ph);
      check({ph, ".empty"}, w1(mpeg_empty),     w1(m_q.size() == 0));
      check({ph, ".pfull"}, w1(mpeg_prog_full), w1(m_q.size() >= PROG_FULL));
      check({ph, ".dout"},  w8(mpeg_out),       w8(m_dout));
      check({ph, ".vid"},   vid_cnt,            m_vid);
      check({ph, ".in"},    misc_in_cnt,        m_in);
      check({ph, ".out"},   vbuf_out_cnt,       m_out);
      check({ph, ".ovf"},   w1(overflow),       w1(m_ovf));
      check({ph, ".done"},  w1(stream_done),    w1(m_done));
   endtask

   // One clock: drive inputs, advance the model at the edge, compare after it.
   task automatic step(input string ph, input bit en, input bit we, input logic [7:0] d,
                       input bit rd, input bit se);
      clk_en     = en;
      mpeg_in_en = we;
      mpeg_in    = d;
      mpeg_rd    = rd;
      stream_end = se;
      @(posedge clk);
      model_edge(en, we, d, rd, se);
      #1;
      check_all(ph);
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      clk_en     = 1'b1;
      mpeg_in_en = 1'b0;
      mpeg_in    = 8'h00;
      mpeg_rd    = 1'b0;
      stream_end = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_all("rst");
      rst_n = 1'b1;
   endtask

   logic [7:0] sc_bytes [17] = '{8'h00, 8'h00, 8'h01, 8'hBA,
                                 8'h00, 8'h00, 8'h01, 8'hE0,
                                 8'h00, 8'h00, 8'h00, 8'h01, 8'hE5,
                                 8'h00, 8'h00, 8'h01, 8'hC0};
   logic [7:0] pick [5] = '{8'h00, 8'h01, 8'hE3, 8'hB0, 8'hEF};

   initial begin
      int cyc;
      bit we, rd;

      // Reset values
      do_reset();
      check("rst.out_zero", w8(mpeg_out), 32'd0);
      check("rst.empty1",   w1(mpeg_empty), 32'd1);

      // Pass-through of 1000 random bytes with random read pacing
      cyc = 0;
      while ((m_in < 1000 || m_q.size() > 0) && cyc < 20000) begin
         we = (m_in < 1000) && !mpeg_prog_full && ($urandom_range(3) != 0);
         rd = !mpeg_empty && ($urandom_range(2) != 0);
         step("pt", 1'b1, we, 8'($urandom), rd, 1'b0);
         cyc++;
      end
      check("pt.in_total",  misc_in_cnt,  32'd1000);
      check("pt.out_total", vbuf_out_cnt, 32'd1000);
      check("pt.overflow",  w1(overflow), 32'd0);

      // Back-pressure and overflow
      do_reset();
      for (int i = 1; i <= DEPTH; i++) begin
         step("bp", 1'b1, 1'b1, 8'($urandom), 1'b0, 1'b0);
         if (i == PROG_FULL - 1) check("bp.pf_239", w1(mpeg_prog_full), 32'd0);
         if (i == PROG_FULL)     check("bp.pf_240", w1(mpeg_prog_full), 32'd1);
      end
      check("bp.in_256", misc_in_cnt, 32'd256);
      step("bp_rw", 1'b1, 1'b1, 8'($urandom), 1'b1, 1'b0);
      check("bp.rw_ovf", w1(overflow), 32'd0);
      check("bp.rw_in",  misc_in_cnt, 32'd257);
      step("bp_ov", 1'b1, 1'b1, 8'($urandom), 1'b0, 1'b0);
      check("bp.ovf_set", w1(overflow), 32'd1);
      check("bp.ovf_in",  misc_in_cnt, 32'd257);
      for (int i = 0; i < DEPTH; i++) step("bp_drain", 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      check("bp.drained", w1(mpeg_empty), 32'd1);
      step("bp_rd_empty", 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      check("bp.rd_empty_cnt", vbuf_out_cnt, 32'd257);

      // Start codes, directed then biased random
      do_reset();
      foreach (sc_bytes[i]) step("sc", 1'b1, 1'b1, sc_bytes[i], ($urandom_range(1) == 1), 1'b0);
      check("sc.vid2", vid_cnt, 32'd2);
      for (int i = 0; i < 600; i++)
         step("sc_rnd", 1'b1, ($urandom_range(4) != 0), pick[$urandom_range(4)],
              !mpeg_empty && ($urandom_range(1) == 1), 1'b0);

      // End of stream, clock-enable freeze, drain
      do_reset();
      for (int i = 0; i < 20; i++) step("eos_wr", 1'b1, 1'b1, 8'($urandom), 1'b0, 1'b0);
      for (int i = 0; i < 5; i++)
         step("freeze", 1'b0, 1'b1, 8'($urandom), 1'b1, 1'b1);
      check("frz.in", misc_in_cnt, 32'd20);
      cyc = 0;
      while (!mpeg_empty && cyc < 100) begin
         step("eos_drain", 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
         cyc++;
      end
      check("eos.empty",    w1(mpeg_empty),  32'd1);
      check("eos.not_yet",  w1(stream_done), 32'd0);
      step("eos_done", 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
      check("eos.done",     w1(stream_done), 32'd1);
      step("eos_hold", 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
      check("eos.hold",     w1(stream_done), 32'd1);
      step("eos_new", 1'b1, 1'b1, 8'h5A, 1'b0, 1'b1);
      check("eos.new_clr",  w1(stream_done), 32'd0);
      step("eos_rd", 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
      step("eos_re", 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
      step("eos_drop", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      check("eos.drop_clr", w1(stream_done), 32'd0);

      // Asynchronous reset in the middle of a stream
      for (int i = 0; i < 30; i++) step("mid_wr", 1'b1, 1'b1, 8'($urandom), 1'b0, 1'b0);
      rst_n = 1'b0;
      #2;
      check("mid.empty", w1(mpeg_empty),  32'd1);
      check("mid.in",    misc_in_cnt,     32'd0);
      check("mid.dout",  w8(mpeg_out),    32'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 40; i++)
         step("post", 1'b1, ($urandom_range(1) == 1), 8'($urandom),
              !mpeg_empty && ($urandom_range(1) == 1), 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
